// File: rtl/ar_pkg.sv
// rtl/ar_pkg.sv - state encoding, default widths and address step helper for ar_seq
package ar_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  localparam int unsigned AW_DEF     = 16;
  localparam int unsigned LW_DEF     = 4;
  localparam int unsigned STRIDE_DEF = 1;
  localparam int unsigned AW_MAX     = 32;

  // Returns {carry_or_borrow, sum} of an aw-bit add/subtract; operands arrive zero-extended.
  // A borrow leaves every bit from position aw upward set, so raw[aw] covers both cases.
  function automatic logic [AW_MAX:0] step_calc(input logic [AW_MAX-1:0] a,
                                                input logic [AW_MAX-1:0] b,
                                                input logic              sub,
                                                input int unsigned       aw);
    logic [AW_MAX:0]   raw;
    logic [AW_MAX-1:0] mask;
    raw  = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    mask = {AW_MAX{1'b1}} >> (AW_MAX - aw);
    return {raw[aw], raw[AW_MAX-1:0] & mask};
  endfunction

endpackage

// File: rtl/ar_step.sv
// rtl/ar_step.sv - AW-bit adder/subtractor with carry/borrow out, shared by +/-1 and stride paths
module ar_step
  import ar_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
) (
  input  logic [AW-1:0] a,
  input  logic [AW-1:0] b,
  input  logic          sub,
  output logic [AW-1:0] sum,
  output logic          cout
);

  logic [AW_MAX:0] res;
  logic            unused_res;

  // Widen to the package helper's fixed width, then take back the AW-bit sum and the carry
  always_comb begin
    res        = step_calc(AW_MAX'(a), AW_MAX'(b), sub, AW);
    sum        = res[AW-1:0];
    cout       = res[AW_MAX];
    unused_res = ^res;
  end

endmodule

// File: rtl/ar_seq.sv
// rtl/ar_seq.sv - address register with load, +/-1 step and strided burst sequencing
module ar_seq
  import ar_pkg::*;
#(
  parameter int unsigned AW     = AW_DEF,
  parameter int unsigned LW     = LW_DEF,
  parameter int unsigned STRIDE = STRIDE_DEF
) (
  input  logic          clk_sys,
  input  logic          clr,
  input  logic [AW-1:0] w,
  input  logic          l,
  input  logic          p1,
  input  logic          m1,
  input  logic          bst,
  input  logic [LW-1:0] blen,
  input  logic          nxt,
  input  logic          abrt,
  output logic [AW-1:0] ar,
  output logic          bvld,
  output logic          blast,
  output logic          busy,
  output logic          wrap
);

  state_e        state_q, state_d;
  logic [AW-1:0] ar_q, ar_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          wrap_q, wrap_d;

  logic [AW-1:0] step_b;
  logic          step_sub;
  logic [AW-1:0] step_sum;
  logic          step_cout;

  // Step operand: +STRIDE while bursting, otherwise +1 or -1 chosen by m1
  always_comb begin
    step_b   = AW'(1);
    step_sub = 1'b0;
    if (state_q == ST_BURST) begin
      step_b = AW'(STRIDE);
    end else begin
      step_sub = m1;
    end
  end

  ar_step #(.AW(AW)) u_step (
    .a    (ar_q),
    .b    (step_b),
    .sub  (step_sub),
    .sum  (step_sum),
    .cout (step_cout)
  );

  // Next-state: IDLE command priority bst > l > single step; BURST honours only abrt and nxt
  always_comb begin
    state_d = state_q;
    ar_d    = ar_q;
    cnt_d   = cnt_q;
    wrap_d  = wrap_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bst && (blen != '0)) begin
          ar_d    = w;
          cnt_d   = blen - LW'(1);
          wrap_d  = 1'b0;
          state_d = ST_BURST;
        end else if (l) begin
          ar_d   = w;
          wrap_d = 1'b0;
        end else if (p1 ^ m1) begin
          ar_d   = step_sum;
          wrap_d = wrap_q | step_cout;
        end
      end
      ST_BURST: begin
        if (abrt) begin
          state_d = ST_IDLE;
        end else if (nxt) begin
          if (cnt_q != '0) begin
            ar_d   = step_sum;
            cnt_d  = cnt_q - LW'(1);
            wrap_d = wrap_q | step_cout;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; clr forces everything back to the idle, zeroed state
  always_ff @(posedge clk_sys) begin
    if (clr) begin
      state_q <= ST_IDLE;
      ar_q    <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ar_q    <= ar_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
    end
  end

  // Outputs decoded purely from registered state
  always_comb begin
    ar    = ar_q;
    wrap  = wrap_q;
    busy  = (state_q == ST_BURST);
    bvld  = (state_q == ST_BURST);
    blast = (state_q == ST_BURST) && (cnt_q == '0);
  end

endmodule

// File: tb/tb_ar_seq.sv
// tb/tb_ar_seq.sv - self-checking bench for ar_seq with stride-1 and stride-4 instances
module tb_ar_seq;

  localparam int MOD = 65536;

  logic        clk_sys = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] w = '0;
  logic        l = 1'b0, p1 = 1'b0, m1 = 1'b0, bst = 1'b0, nxt = 1'b0, abrt = 1'b0;
  logic [3:0]  blen = '0;

  logic [15:0] ar_a, ar_b;
  logic        bvld_a, blast_a, busy_a, wrap_a;
  logic        bvld_b, blast_b, busy_b, wrap_b;
  logic [19:0] obs [2];

  int n_cmp = 0;
  int n_bad = 0;

  int m_ar   [2];
  bit m_bur  [2];
  int m_left [2];
  bit m_wrap [2];
  int stride [2] = '{1, 4};

  always #5 clk_sys = ~clk_sys;

  ar_seq #(.AW(16), .LW(4), .STRIDE(1)) u_s1 (
    .clk_sys(clk_sys), .clr(clr), .w(w), .l(l), .p1(p1), .m1(m1), .bst(bst), .blen(blen),
    .nxt(nxt), .abrt(abrt), .ar(ar_a), .bvld(bvld_a), .blast(blast_a), .busy(busy_a), .wrap(wrap_a)
  );

  ar_seq #(.AW(16), .LW(4), .STRIDE(4)) u_s4 (
    .clk_sys(clk_sys), .clr(clr), .w(w), .l(l), .p1(p1), .m1(m1), .bst(bst), .blen(blen),
    .nxt(nxt), .abrt(abrt), .ar(ar_b), .bvld(bvld_b), .blast(blast_b), .busy(busy_b), .wrap(wrap_b)
  );

  assign obs[0] = {ar_a, bvld_a, blast_a, busy_a, wrap_a};
  assign obs[1] = {ar_b, bvld_b, blast_b, busy_b, wrap_b};

  // Reference: address as an integer modulo 2^16, burst tracked as beats still to deliver
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (clr) begin
        m_ar[i] = 0; m_bur[i] = 0; m_left[i] = 0; m_wrap[i] = 0;
      end else if (m_bur[i]) begin
        if (abrt) begin
          m_bur[i] = 0;
        end else if (nxt) begin
          if (m_left[i] == 1) begin
            m_bur[i] = 0; m_left[i] = 0;
          end else begin
            if (m_ar[i] + stride[i] >= MOD) m_wrap[i] = 1;
            m_ar[i] = (m_ar[i] + stride[i]) % MOD;
            m_left[i] = m_left[i] - 1;
          end
        end
      end else if (bst && blen != 0) begin
        m_ar[i] = int'(w); m_left[i] = int'(blen); m_bur[i] = 1; m_wrap[i] = 0;
      end else if (l) begin
        m_ar[i] = int'(w); m_wrap[i] = 0;
      end else if (p1 && !m1) begin
        if (m_ar[i] == MOD - 1) m_wrap[i] = 1;
        m_ar[i] = (m_ar[i] + 1) % MOD;
      end else if (m1 && !p1) begin
        if (m_ar[i] == 0) begin
          m_wrap[i] = 1; m_ar[i] = MOD - 1;
        end else begin
          m_ar[i] = m_ar[i] - 1;
        end
      end
    end
  endtask

  function automatic logic [19:0] exp_vec(input int i);
    logic [15:0] a;
    a = 16'(m_ar[i]);
    return {a, m_bur[i], m_bur[i] && (m_left[i] == 1), m_bur[i], m_wrap[i]};
  endfunction

  task automatic cyc(input logic [15:0] wv, input logic lv, input logic p1v, input logic m1v,
                     input logic bstv, input logic [3:0] blv, input logic nxtv,
                     input logic abrtv, input logic clrv);
    w = wv; l = lv; p1 = p1v; m1 = m1v; bst = bstv; blen = blv; nxt = nxtv; abrt = abrtv; clr = clrv;
    @(posedge clk_sys);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    cyc(16'h5a5a, 1, 1, 0, 1, 4'd3, 1, 0, 1);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (obs[i] !== 20'h0) begin
        n_bad++;
        $display("FAIL reset dut%0d {ar,bvld,blast,busy,wrap}=%h expected %h", i, obs[i], 20'h0);
      end
    end
    cyc(16'h0, 0, 0, 0, 0, 4'd0, 0, 0, 0);
  endtask

  task automatic test_load_step();
    logic [2:0]  ctl [5] = '{3'b100, 3'b010, 3'b001, 3'b001, 3'b011};
    logic [15:0] ea  [5] = '{16'hbeef, 16'hbef0, 16'hbeef, 16'hbeee, 16'hbeee};
    for (int k = 0; k < 5; k++) begin
      cyc(16'hbeef, ctl[k][2], ctl[k][1], ctl[k][0], 0, 4'd0, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (obs[i] !== {ea[k], 4'b0000} || obs[i] !== exp_vec(i)) begin
          n_bad++;
          $display("FAIL load_step[%0d] dut%0d got %h expected %h", k, i, obs[i], {ea[k], 4'b0000});
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [2:0]  ctl [4] = '{3'b100, 3'b010, 3'b001, 3'b100};
    logic [15:0] ws  [4] = '{16'hffff, 16'h0, 16'h0, 16'h1234};
    logic [16:0] ex  [4] = '{{16'hffff, 1'b0}, {16'h0000, 1'b1}, {16'hffff, 1'b1}, {16'h1234, 1'b0}};
    for (int k = 0; k < 4; k++) begin
      cyc(ws[k], ctl[k][2], ctl[k][1], ctl[k][0], 0, 4'd0, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if ({obs[i][19:4], obs[i][0]} !== ex[k] || obs[i] !== exp_vec(i)) begin
          n_bad++;
          $display("FAIL wrap[%0d] dut%0d got %h expected ar,wrap=%h", k, i, obs[i], ex[k]);
        end
      end
    end
  endtask

  task automatic test_burst_wrap();
    logic [19:0] ex [4] = '{{16'hfffe, 4'b1010}, {16'hffff, 4'b1010}, {16'h0000, 4'b1111}, {16'h0000, 4'b0001}};
    cyc(16'hfffe, 0, 0, 0, 1, 4'd3, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (obs[0] !== ex[k]) begin
        n_bad++;
        $display("FAIL burst_wrap[%0d] dut0 got %h expected %h", k, obs[0], ex[k]);
      end
      n_cmp++;
      if (obs[1] !== exp_vec(1)) begin
        n_bad++;
        $display("FAIL burst_wrap[%0d] dut1 got %h expected %h", k, obs[1], exp_vec(1));
      end
      if (k < 3) cyc(16'h1111, 1, 1, 0, 1, 4'd2, 1, 0, 0);
    end
  endtask

  task automatic test_backpressure();
    logic [19:0] ex [6] = '{{16'h0100, 4'b1010}, {16'h0100, 4'b1010}, {16'h0100, 4'b1010},
                            {16'h0100, 4'b1010}, {16'h0104, 4'b1110}, {16'h0104, 4'b0000}};
    for (int k = 0; k < 6; k++) begin
      case (k)
        0:       cyc(16'h0100, 0, 0, 0, 1, 4'd2, 0, 0, 0);
        2:       cyc(16'h5555, 1, 0, 0, 0, 4'd0, 0, 0, 0);
        1, 3:    cyc(16'h0000, 0, 1, 0, 0, 4'd0, 0, 0, 0);
        default: cyc(16'h0000, 0, 0, 0, 0, 4'd0, 1, 0, 0);
      endcase
      n_cmp++;
      if (obs[1] !== ex[k]) begin
        n_bad++;
        $display("FAIL backpressure[%0d] dut1 got %h expected %h", k, obs[1], ex[k]);
      end
      n_cmp++;
      if (obs[0] !== exp_vec(0)) begin
        n_bad++;
        $display("FAIL backpressure[%0d] dut0 got %h expected %h", k, obs[0], exp_vec(0));
      end
    end
  endtask

  task automatic test_abort_reset();
    cyc(16'h2000, 0, 0, 0, 1, 4'd5, 0, 0, 0);
    cyc(16'h0000, 0, 0, 0, 0, 4'd0, 1, 0, 0);
    cyc(16'h0000, 0, 0, 0, 0, 4'd0, 1, 1, 0);
    n_cmp++;
    if (obs[0] !== {16'h2001, 4'b0000} || obs[1] !== {16'h2004, 4'b0000}) begin
      n_bad++;
      $display("FAIL abort got %h/%h expected %h/%h", obs[0], obs[1], {16'h2001, 4'b0000}, {16'h2004, 4'b0000});
    end
    cyc(16'h2000, 0, 0, 0, 1, 4'd5, 0, 0, 0);
    cyc(16'h0000, 0, 0, 0, 0, 4'd0, 1, 0, 0);
    cyc(16'h0000, 0, 0, 0, 0, 4'd0, 1, 0, 1);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (obs[i] !== 20'h0 || obs[i] !== exp_vec(i)) begin
          n_bad++;
          $display("FAIL clr_mid_burst[%0d] dut%0d got %h expected %h", k, i, obs[i], 20'h0);
        end
      end
      cyc(16'h0000, 0, 0, 0, 0, 4'd0, 1, 0, 0);
    end
  endtask

  task automatic test_corner();
    int          beats;
    int          lasts;
    logic [15:0] last_ar;
    bit          done;
    cyc(16'habcd, 1, 0, 0, 1, 4'd0, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (obs[i] !== {16'habcd, 4'b0000}) begin
        n_bad++;
        $display("FAIL blen0_load dut%0d got %h expected %h", i, obs[i], {16'habcd, 4'b0000});
      end
    end
    cyc(16'h0010, 0, 0, 0, 1, 4'd15, 1, 0, 0);
    beats = 0; lasts = 0; last_ar = '0; done = 0;
    for (int k = 0; k < 40; k++) begin
      if (!bvld_a) begin
        done = 1;
        break;
      end
      beats++;
      if (blast_a) lasts++;
      last_ar = ar_a;
      cyc(16'h0000, 0, 0, 0, 0, 4'd0, 1, 0, 0);
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL blen15_timeout bvld still high after 40 cycles, expected low by 15");
    end
    n_cmp++;
    if (beats !== 15 || lasts !== 1 || last_ar !== 16'h001e) begin
      n_bad++;
      $display("FAIL blen15 beats=%0d blasts=%0d last=%h expected 15/1/001e", beats, lasts, last_ar);
    end
    n_cmp++;
    if (obs[1] !== exp_vec(1)) begin
      n_bad++;
      $display("FAIL blen15 dut1 got %h expected %h", obs[1], exp_vec(1));
    end
  endtask

  task automatic test_random();
    logic [15:0] wv;
    for (int k = 0; k < 2000; k++) begin
      wv = ($urandom_range(3) == 0) ? (16'hfff0 | 16'($urandom_range(15))) : 16'($urandom);
      cyc(wv, $urandom_range(7) == 0, $urandom_range(2) == 0, $urandom_range(2) == 0,
          $urandom_range(5) == 0, 4'($urandom_range(15)), $urandom_range(9) < 6,
          $urandom_range(19) == 0, $urandom_range(63) == 0);
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (obs[i] !== exp_vec(i)) begin
          n_bad++;
          $display("FAIL random[%0d] dut%0d got %h expected %h", k, i, obs[i], exp_vec(i));
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_ar[i] = 0; m_bur[i] = 0; m_left[i] = 0; m_wrap[i] = 0;
    end
    test_reset();
    test_load_step();
    test_wrap();
    test_burst_wrap();
    test_backpressure();
    test_abort_reset();
    test_corner();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
